// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out transmit controller.
// Counter widths cover the largest legal frame (32 bits) and gap (15 cycles).
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int DATA_W_DEF  = 16;
  localparam int GAP_CYC_DEF = 1;
  localparam int BIT_CNT_W   = 5;
  localparam int GAP_CNT_W   = 4;

endpackage

// File: rtl/piso_shift.sv
// Shift register for the serial transmitter: parallel load, MSB-first shift-out.
// Load takes priority over shift; zeros are shifted in at the LSB end.
module piso_shift
  import piso_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              dout
);

  logic [DATA_W-1:0] shReg_q, shReg_d;

  always_comb begin
    shReg_d = shReg_q;
    if (load) begin
      shReg_d = din;
    end else if (shift) begin
      shReg_d = {shReg_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shReg_q <= '0;
    end else begin
      shReg_q <= shReg_d;
    end
  end

  assign dout = shReg_q[DATA_W-1];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Two-requester serial transmit controller: round-robin arbitration in IDLE,
// MSB-first frame serialization in SHIFT, optional idle gap after each frame.
module piso_tx_ctrl
  import piso_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              sdout,
  output logic              sdout_valid,
  output logic              sfirst,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [BIT_CNT_W-1:0] BIT_TOP = BIT_CNT_W'(DATA_W - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_TOP = GAP_CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_e               state_q, state_d;
  logic [BIT_CNT_W-1:0] bitCnt_q, bitCnt_d;
  logic [GAP_CNT_W-1:0] gapCnt_q, gapCnt_d;
  logic                 grant_q, grant_d;
  logic                 rrLast_q, rrLast_d;

  logic              gnt0, gnt1, load, shiftEn, shDout;
  logic [DATA_W-1:0] loadData;

  // rrLast_q remembers who was served last; the other side wins a tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == ST_IDLE) begin
      gnt0 = req0_valid & (~req1_valid | rrLast_q);
      gnt1 = req1_valid & (~req0_valid | ~rrLast_q);
    end
  end

  assign load     = gnt0 | gnt1;
  assign loadData = gnt1 ? req1_data : req0_data;
  assign shiftEn  = (state_q == ST_SHIFT);

  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    gapCnt_d = gapCnt_q;
    grant_d  = grant_q;
    rrLast_d = rrLast_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d  = ST_SHIFT;
          bitCnt_d = BIT_TOP;
          grant_d  = gnt1;
          rrLast_d = gnt1;
        end
      end
      ST_SHIFT: begin
        if (bitCnt_q == '0) begin
          if (GAP_CYC == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_GAP;
            gapCnt_d = GAP_TOP;
          end
        end else begin
          bitCnt_d = bitCnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (gapCnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gapCnt_d = gapCnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset leaves rrLast_q pointing at requester 1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bitCnt_q <= '0;
      gapCnt_q <= '0;
      grant_q  <= 1'b0;
      rrLast_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      gapCnt_q <= gapCnt_d;
      grant_q  <= grant_d;
      rrLast_q <= rrLast_d;
    end
  end

  piso_shift #(
    .DATA_W(DATA_W)
  ) u_shift (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .shift(shiftEn),
    .din  (loadData),
    .dout (shDout)
  );

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign sdout       = shiftEn & shDout;
  assign sdout_valid = shiftEn;
  assign sfirst      = shiftEn & (bitCnt_q == BIT_TOP);
  assign busy        = (state_q != ST_IDLE);
  assign grant_id    = grant_q;

endmodule
